// File: rtl/matmul_pkg.sv
// Shared widths and the in-flight tracking entry for the 3x3 matmul
// scheduler and its datapath.
package matmul_pkg;
   localparam int MAT_DIM = 3;
   localparam int ELEM_W  = 3;
   localparam int PROD_W  = 8;
   localparam int MAT_W   = MAT_DIM * MAT_DIM * ELEM_W;
   localparam int RES_W   = MAT_DIM * MAT_DIM * PROD_W;

   typedef struct packed {
      logic valid;
      logic id;
   } track_t;
endpackage

// File: rtl/mm_result_fifo.sv
// Synchronous result FIFO holding {id, product} entries.
// Ports: push_i/wdata_i write, pop_i/rdata_o read head, count_o/empty_o/full_o.
module mm_result_fifo
   import matmul_pkg::*;
#(
   parameter int WIDTH = RES_W + 1,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [AW:0]      count_o,
   output logic             empty_o,
   output logic             full_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      do_pop  = pop_i && !empty_o;
      // A pop frees the head slot in the same cycle, so push on full is legal with it.
      do_push = push_i && (!full_o || do_pop);
      if (do_push) begin
         mem_d[wr_q] = wdata_i;
         wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/matmul_job_scheduler.sv
// Two-requester round-robin job scheduler for the pipelined 3x3 matmul datapath.
// Ports: req0/req1 valid/ready jobs, mm_inp1/mm_inp2/mm_outp datapath, res_* tagged results.
module matmul_job_scheduler
   import matmul_pkg::*;
#(
   parameter int PIPE_LAT   = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [MAT_W-1:0] req0_a,
   input  logic [MAT_W-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [MAT_W-1:0] req1_a,
   input  logic [MAT_W-1:0] req1_b,
   output logic [MAT_W-1:0] mm_inp1,
   output logic [MAT_W-1:0] mm_inp2,
   input  logic [RES_W-1:0] mm_outp,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] res_data,
   output logic             res_id
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                  last_q, last_d;
   logic [MAT_W-1:0]      a_q, a_d;
   logic [MAT_W-1:0]      b_q, b_d;
   track_t [PIPE_LAT:0]   track_q, track_d;
   track_t                trk_in;
   logic                  hs0, hs1;
   logic                  credit;
   logic [31:0]           occ;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_empty;
   logic                  fifo_full;

   // Credits cover both buffered and in-flight results, so every
   // product leaving the datapath is guaranteed a FIFO slot.
   always_comb begin
      occ = 32'(fifo_count);
      for (int i = 0; i <= PIPE_LAT; i++) begin
         occ = occ + 32'(track_q[i].valid);
      end
      credit = rst_n && !fifo_full && (occ < 32'(FIFO_DEPTH));
   end

   // Each ready looks only at the other side's valid and the pointer.
   assign req0_ready = credit && (last_q || !req1_valid);
   assign req1_ready = credit && (!last_q || !req0_valid);

   always_comb begin
      hs0    = req0_valid && req0_ready;
      hs1    = req1_valid && req1_ready;
      last_d = last_q;
      a_d    = a_q;
      b_d    = b_q;
      if (hs0) begin
         last_d = 1'b0;
         a_d    = req0_a;
         b_d    = req0_b;
      end else if (hs1) begin
         last_d = 1'b1;
         a_d    = req1_a;
         b_d    = req1_b;
      end
      trk_in  = track_t'{valid: hs0 || hs1, id: hs1};
      track_d = {track_q[PIPE_LAT-1:0], trk_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q  <= 1'b1;
         a_q     <= '0;
         b_q     <= '0;
         track_q <= '0;
      end else begin
         last_q  <= last_d;
         a_q     <= a_d;
         b_q     <= b_d;
         track_q <= track_d;
      end
   end

   assign mm_inp1 = a_q;
   assign mm_inp2 = b_q;

   mm_result_fifo #(
      .WIDTH (RES_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (track_q[PIPE_LAT].valid),
      .wdata_i ({track_q[PIPE_LAT].id, mm_outp}),
      .pop_i   (res_valid && res_ready),
      .rdata_o ({res_id, res_data}),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign res_valid = !fifo_empty;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed bench for matmul_job_scheduler with a datapath model and
// an in-order result scoreboard.
module tb_matmul_job_scheduler;
   import matmul_pkg::*;

   localparam int PIPE_LAT   = 3;
   localparam int FIFO_DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [MAT_W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [MAT_W-1:0] mm_inp1, mm_inp2;
   logic [RES_W-1:0] mm_outp;
   logic             res_valid, res_ready;
   logic [RES_W-1:0] res_data;
   logic             res_id;

   int checks = 0;
   int errors = 0;

   logic [RES_W:0] sb[$];
   logic           hs_ids[$];
   logic           hold_v = 1'b0;
   logic [RES_W:0] hold_d = '0;

   logic [RES_W-1:0] dp_pipe [PIPE_LAT];

   always #5 clk = ~clk;

   matmul_job_scheduler #(
      .PIPE_LAT   (PIPE_LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .mm_inp1    (mm_inp1),
      .mm_inp2    (mm_inp2),
      .mm_outp    (mm_outp),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_id     (res_id)
   );

   function automatic logic [RES_W-1:0] mm_ref(logic [MAT_W-1:0] a,
                                                logic [MAT_W-1:0] b);
      logic [RES_W-1:0] p;
      int s;
      p = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            s = 0;
            for (int k = 0; k < 3; k++) begin
               s = s + int'(a[9*r+3*k +: 3]) * int'(b[9*k+3*c +: 3]);
            end
            p[24*r+8*c +: 8] = 8'(s);
         end
      end
      return p;
   endfunction

   // Datapath model: PIPE_LAT register stages behind the operand registers.
   always @(posedge clk) begin
      dp_pipe[0] <= mm_ref(mm_inp1, mm_inp2);
      for (int i = 1; i < PIPE_LAT; i++) begin
         dp_pipe[i] <= dp_pipe[i-1];
      end
   end
   assign mm_outp = dp_pipe[PIPE_LAT-1];

   task automatic check(string tag, logic [RES_W:0] obs, logic [RES_W:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Monitor at the falling edge: predicts handshakes and pops at the next rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (req0_valid && req0_ready) begin
            sb.push_back({1'b0, mm_ref(req0_a, req0_b)});
            hs_ids.push_back(1'b0);
         end
         if (req1_valid && req1_ready) begin
            sb.push_back({1'b1, mm_ref(req1_a, req1_b)});
            hs_ids.push_back(1'b1);
         end
         if (hold_v) begin
            check("hold_valid", (RES_W+1)'(res_valid), (RES_W+1)'(1));
            check("hold_data", {res_id, res_data}, hold_d);
         end
         hold_v <= res_valid && !res_ready;
         hold_d <= {res_id, res_data};
         check("push_on_full",
               (RES_W+1)'(dut.u_fifo.push_i && dut.u_fifo.full_o && !dut.u_fifo.pop_i),
               '0);
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               check("res_expected", (RES_W+1)'(sb.size() != 0), (RES_W+1)'(1));
            end else begin
               check("res", {res_id, res_data}, sb.pop_front());
            end
         end
      end else begin
         hold_v <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      sb.delete();
      hs_ids.delete();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      res_ready = 1'b1;
      while ((sb.size() != 0 || res_valid) && n < 100) begin
         tick();
         n++;
      end
      check("drain_sb_empty", (RES_W+1)'(sb.size()), '0);
   endtask

   task automatic latency_job(logic [MAT_W-1:0] a, logic [MAT_W-1:0] b);
      int n;
      int lat;
      req0_a     = a;
      req0_b     = b;
      req0_valid = 1'b1;
      n = 0;
      while (!req0_ready && n < 20) begin
         tick();
         n++;
      end
      check("lat_ready", (RES_W+1)'(req0_ready), (RES_W+1)'(1));
      tick();
      req0_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("latency", (RES_W+1)'(lat), (RES_W+1)'(PIPE_LAT + 1));
   endtask

   initial begin
      logic [MAT_W-1:0] all7;
      logic [MAT_W-1:0] ident;
      logic [MAT_W-1:0] a_rc;
      logic [MAT_W-1:0] b_k;
      logic             stale;
      int               n;

      all7  = {9{3'd7}};
      ident = 27'h1001001;
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_a = '0; req0_b = '0;
      req1_a = '0; req1_b = '0;
      res_ready = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_req0_ready", (RES_W+1)'(req0_ready), '0);
      check("rst_req1_ready", (RES_W+1)'(req1_ready), '0);
      check("rst_mm_inp1", (RES_W+1)'(mm_inp1), '0);
      check("rst_mm_inp2", (RES_W+1)'(mm_inp2), '0);
      check("rst_res_valid", (RES_W+1)'(res_valid), '0);
      check("rst_res", {res_id, res_data}, '0);
      rst_n = 1'b1;
      #1;
      check("first_cycle_ready", (RES_W+1)'(req0_ready), (RES_W+1)'(1));

      // Single job: identity x all 7s
      latency_job(ident, all7);
      check("t1_data", (RES_W+1)'(res_data), (RES_W+1)'({9{8'h07}}));
      check("t1_id", (RES_W+1)'(res_id), '0);
      drain();

      // Both requesters, round robin from reset
      do_reset();
      req0_a = all7; req0_b = all7;
      req1_a = all7; req1_b = all7;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      n = 0;
      while (hs_ids.size() < 8 && n < 200) begin
         tick();
         n++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("rr_count", (RES_W+1)'(hs_ids.size()), (RES_W+1)'(8));
      for (int i = 0; i < 8 && i < hs_ids.size(); i++) begin
         check("rr_grant", (RES_W+1)'(hs_ids[i]), (RES_W+1)'(i % 2));
      end
      drain();

      // Stall: res_ready low
      hs_ids.delete();
      res_ready  = 1'b0;
      req0_a     = ident;
      req0_b     = {9{3'd5}};
      req0_valid = 1'b1;
      repeat (20) tick();
      check("stall_count", (RES_W+1)'(hs_ids.size()), (RES_W+1)'(FIFO_DEPTH));
      check("stall_ready", (RES_W+1)'(req0_ready), '0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      repeat (10) tick();
      check("one_pop_one_issue", (RES_W+1)'(hs_ids.size()), (RES_W+1)'(FIFO_DEPTH + 1));
      check("stall_ready2", (RES_W+1)'(req0_ready), '0);
      req0_valid = 1'b0;
      drain();

      // Eight distinct back-to-back jobs
      hs_ids.delete();
      a_rc = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            a_rc[9*r+3*c +: 3] = 3'(r + c);
         end
      end
      for (int k = 0; k < 8; k++) begin
         b_k = '0;
         for (int d = 0; d < 3; d++) begin
            b_k[12*d +: 3] = 3'(k);
         end
         req0_a     = a_rc;
         req0_b     = b_k;
         req0_valid = 1'b1;
         n = 0;
         while (!req0_ready && n < 50) begin
            tick();
            n++;
         end
         tick();
      end
      req0_valid = 1'b0;
      drain();
      check("stream_count", (RES_W+1)'(hs_ids.size()), (RES_W+1)'(8));

      // Reset with results in flight and buffered
      hs_ids.delete();
      res_ready  = 1'b0;
      req0_a     = all7;
      req0_b     = ident;
      req0_valid = 1'b1;
      n = 0;
      while (hs_ids.size() < 4 && n < 50) begin
         tick();
         n++;
      end
      req0_valid = 1'b0;
      tick();
      tick();
      check("pre_rst_valid", (RES_W+1)'(res_valid), (RES_W+1)'(1));
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", (RES_W+1)'(res_valid), '0);
      check("mid_rst_ready", (RES_W+1)'(req0_ready), '0);
      sb.delete();
      hs_ids.delete();
      tick();
      rst_n     = 1'b1;
      res_ready = 1'b1;
      stale = 1'b0;
      repeat (10) begin
         tick();
         if (res_valid) stale = 1'b1;
      end
      check("no_stale", (RES_W+1)'(stale), '0);
      latency_job(ident, {9{3'd3}});
      check("post_rst_id", (RES_W+1)'(res_id), '0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
